// File: rtl/lsu_control_pkg.sv
// rtl/lsu_control_pkg.sv - shared types for the load/store unit control slice
// Purpose: access-size encodings, FSM state type and the per-size lane mask helper.
// Ports: none (package).
package lsu_control_pkg;

   typedef enum logic [1:0] {
      SIZE_WORD = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_BYTE = 2'b10,
      SIZE_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC0 = 2'b01,
      ACC1 = 2'b10,
      DONE = 2'b11
   } state_e;

   // Byte lanes touched by an access of the given size, before offset shifting.
   function automatic logic [3:0] lane_mask(input logic [1:0] size);
      case (size_e'(size))
         SIZE_WORD: return 4'b1111;
         SIZE_HALF: return 4'b0011;
         SIZE_BYTE: return 4'b0001;
         default:   return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/lsu_control_align.sv
// rtl/lsu_control_align.sv - combinational byte-lane shifting, masking and load extension
// Purpose: derive both memory beats of an access (lanes and store data) and the extended load result.
// Ports: offset/size/ld_unsigned describe the access; st_data is the store data; lo_word/hi_word
//        are the first and second read words; be0/wdata0 and be1/wdata1 are the two beats;
//        split flags a two-beat access; ld_data is the extended load result.
module lsu_align
   import lsu_control_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        ld_unsigned,
   input  logic [31:0] st_data,
   input  logic [31:0] lo_word,
   input  logic [31:0] hi_word,
   output logic [3:0]  be0,
   output logic [3:0]  be1,
   output logic [31:0] wdata0,
   output logic [31:0] wdata1,
   output logic        split,
   output logic [31:0] ld_data
);

   logic [5:0]  shamt;
   logic [7:0]  be_wide;
   logic [63:0] wd_wide;
   logic [31:0] rd_shift;

   // Working in a 64-bit window makes the second beat simply the upper half:
   // the overflow lanes and the store data shifted right by 8*(4-offset).
   always_comb begin
      shamt    = {1'b0, offset, 3'b000};
      be_wide  = {4'b0000, lane_mask(size)} << offset;
      wd_wide  = {32'h0, st_data} << shamt;
      rd_shift = 32'({hi_word, lo_word} >> shamt);
      be0      = be_wide[3:0];
      be1      = be_wide[7:4];
      wdata0   = wd_wide[31:0];
      wdata1   = wd_wide[63:32];
      split    = |be_wide[7:4];
      case (size_e'(size))
         SIZE_HALF: ld_data = {{16{~ld_unsigned & rd_shift[15]}}, rd_shift[15:0]};
         SIZE_BYTE: ld_data = {{24{~ld_unsigned & rd_shift[7]}}, rd_shift[7:0]};
         default:   ld_data = rd_shift;
      endcase
   end

endmodule

// File: rtl/lsu_control.sv
// rtl/lsu_control.sv - load/store unit control FSM with misaligned split support
// Purpose: turns one decoded load/store into one or two word-aligned memory beats.
// Ports: clk/reset; mem_read/mem_write/inst_size/ld_unsigned/addr/wdata from decode/ALU;
//        stall/rdata/done/err to the pipeline; dmem_* is the data-memory request/ack port.
module lsu_control
   import lsu_control_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        inst_size,
   input  logic              ld_unsigned,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              err,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata
);

   state_e            state_q, state_d;
   logic [1:0]        off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              dmem_req_q, dmem_req_d;
   logic              dmem_we_q, dmem_we_d;
   logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
   logic [3:0]        dmem_be_q, dmem_be_d;
   logic [31:0]       dmem_wdata_q, dmem_wdata_d;

   logic [1:0]  a_off, a_size;
   logic        a_uns, a_split;
   logic [31:0] a_st, a_lo, a_hi, a_wd0, a_wd1, a_ld;
   logic [3:0]  a_be0, a_be1;

   // In IDLE the aligner sees the live request so the first beat is ready on
   // entry to ACC0; afterwards it works from the latched copy.
   always_comb begin
      a_off  = (state_q == IDLE) ? addr[1:0]   : off_q;
      a_size = (state_q == IDLE) ? inst_size   : size_q;
      a_uns  = (state_q == IDLE) ? ld_unsigned : uns_q;
      a_st   = (state_q == IDLE) ? wdata       : wdata_q;
      a_lo   = (state_q == ACC1) ? lo_q        : dmem_rdata;
      a_hi   = (state_q == ACC1) ? dmem_rdata  : 32'h0;
   end

   lsu_align u_align (
      .offset     (a_off),
      .size       (a_size),
      .ld_unsigned(a_uns),
      .st_data    (a_st),
      .lo_word    (a_lo),
      .hi_word    (a_hi),
      .be0        (a_be0),
      .be1        (a_be1),
      .wdata0     (a_wd0),
      .wdata1     (a_wd1),
      .split      (a_split),
      .ld_data    (a_ld)
   );

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      size_d       = size_q;
      uns_d        = uns_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      lo_d         = lo_q;
      rdata_d      = rdata_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_be_d    = dmem_be_q;
      dmem_wdata_d = dmem_wdata_q;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               if ((mem_read && mem_write) || size_e'(inst_size) == SIZE_ILL) begin
                  // Illegal request: report it without touching memory.
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d      = ACC0;
                  off_d        = addr[1:0];
                  size_d       = inst_size;
                  uns_d        = ld_unsigned;
                  we_d         = mem_write;
                  wdata_d      = wdata;
                  dmem_req_d   = 1'b1;
                  dmem_we_d    = mem_write;
                  dmem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                  dmem_be_d    = a_be0;
                  dmem_wdata_d = a_wd0;
               end
            end
         end
         ACC0: begin
            if (dmem_ack) begin
               lo_d = dmem_rdata;
               if (a_split) begin
                  state_d      = ACC1;
                  dmem_addr_d  = dmem_addr_q + ADDR_W'(4);
                  dmem_be_d    = a_be1;
                  dmem_wdata_d = a_wd1;
               end else begin
                  state_d    = DONE;
                  done_d     = 1'b1;
                  dmem_req_d = 1'b0;
                  dmem_we_d  = 1'b0;
                  dmem_be_d  = 4'b0000;
                  if (!we_q) rdata_d = a_ld;
               end
            end
         end
         ACC1: begin
            if (dmem_ack) begin
               state_d    = DONE;
               done_d     = 1'b1;
               dmem_req_d = 1'b0;
               dmem_we_d  = 1'b0;
               dmem_be_d  = 4'b0000;
               if (!we_q) rdata_d = a_ld;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         off_q        <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         lo_q         <= '0;
         rdata_q      <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_be_q    <= '0;
         dmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         lo_q         <= lo_d;
         rdata_q      <= rdata_d;
         done_q       <= done_d;
         err_q        <= err_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_be_q    <= dmem_be_d;
         dmem_wdata_q <= dmem_wdata_d;
      end
   end

   assign stall      = (state_q == ACC0) || (state_q == ACC1) ||
                       ((state_q == IDLE) && (mem_read || mem_write));
   assign rdata      = rdata_q;
   assign done       = done_q;
   assign err        = err_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_be    = dmem_be_q;
   assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_lsu_control.sv
// tb/tb_lsu_control.sv - self-checking bench for lsu_control
module tb_lsu_control;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write, ld_unsigned;
   logic [1:0]  inst_size;
   logic [31:0] addr, wdata;
   logic        stall, done, err;
   logic [31:0] rdata;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;

   always #5 clk = ~clk;

   lsu_control #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .inst_size(inst_size), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
      .stall(stall), .rdata(rdata), .done(done), .err(err),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   typedef struct {
      logic        rd, wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] a, wd;
      int          dly;
      logic [31:0] w0, w1;
      int          ntx;
      logic [31:0] a0;
      logic [3:0]  be0;
      logic [31:0] wd0, a1;
      logic [3:0]  be1;
      logic [31:0] wd1;
      logic        we;
      logic        chk_rd;
      logic [31:0] rd_exp;
      logic        err;
      int          stl;
   } vec_t;

   vec_t vecs[12];

   int total = 0;
   int bad   = 0;

   int          n_tx, stall_cnt;
   logic        got_done, got_err, hold_ok, stall_in_done;
   logic [31:0] got_rdata;
   logic [31:0] cap_addr[2], cap_wdata[2];
   logic [3:0]  cap_be[2];
   logic        cap_we[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Runs one request and plays the memory: each beat is acked after dly idle cycles.
   task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd, input int dly,
                             input logic [31:0] w0, input logic [31:0] w1);
      int   wait_n;
      logic new_tx;
      n_tx = 0; stall_cnt = 0; got_done = 0; got_err = 0; hold_ok = 1; stall_in_done = 0;
      wait_n = 0; new_tx = 1;
      @(negedge clk);
      mem_read = rd; mem_write = wr; inst_size = sz; ld_unsigned = uns; addr = a; wdata = wd;
      #1;
      if (stall) stall_cnt++;
      @(negedge clk);
      mem_read = 0; mem_write = 0;
      #1;
      for (int c = 0; c < 40 && !got_done; c++) begin
         if (done) begin
            got_done = 1; got_rdata = rdata; got_err = err; stall_in_done = stall;
         end else begin
            if (stall) stall_cnt++;
            if (dmem_req) begin
               if (new_tx) begin
                  if (n_tx < 2) begin
                     cap_addr[n_tx] = dmem_addr; cap_be[n_tx] = dmem_be;
                     cap_wdata[n_tx] = dmem_wdata; cap_we[n_tx] = dmem_we;
                  end
                  n_tx++; new_tx = 0; wait_n = 0;
               end else if (n_tx <= 2 && (dmem_addr !== cap_addr[n_tx-1] || dmem_be !== cap_be[n_tx-1] ||
                            dmem_wdata !== cap_wdata[n_tx-1] || dmem_we !== cap_we[n_tx-1])) begin
                  hold_ok = 0;
               end
               if (wait_n == dly) begin
                  dmem_ack = 1; dmem_rdata = (n_tx == 1) ? w0 : w1; new_tx = 1;
               end else begin
                  dmem_ack = 0; wait_n++;
               end
            end else begin
               dmem_ack = 0;
            end
            @(negedge clk);
            #1;
         end
      end
      dmem_ack = 0;
   endtask

   initial begin
      //            rd wr sz uns addr            wdata          dly w0             w1            ntx a0             be0   wd0            a1           be1   wd1           we chk rd_exp         err stl
      vecs[0]  = '{1, 0, 0, 0, 32'h100,        32'h0,         1, 32'hDEADBEEF, 32'h0,        1, 32'h100,       4'hF, 32'h0,        32'h0,       4'h0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 3};
      vecs[1]  = '{1, 0, 2, 0, 32'h103,        32'h0,         0, 32'h80123456, 32'h0,        1, 32'h100,       4'h8, 32'h0,        32'h0,       4'h0, 32'h0,        0, 1, 32'hFFFFFF80, 0, 2};
      vecs[2]  = '{1, 0, 2, 1, 32'h103,        32'h0,         0, 32'h80123456, 32'h0,        1, 32'h100,       4'h8, 32'h0,        32'h0,       4'h0, 32'h0,        0, 1, 32'h00000080, 0, 2};
      vecs[3]  = '{0, 1, 0, 0, 32'h1FE,        32'h11223344,  0, 32'h0,        32'h0,        2, 32'h1FC,       4'hC, 32'h33440000, 32'h200,     4'h3, 32'h00001122, 1, 0, 32'h0,        0, 3};
      vecs[4]  = '{1, 0, 1, 0, 32'h7,          32'h0,         0, 32'hAB000000, 32'h000000CD, 2, 32'h4,         4'h8, 32'h0,        32'h8,       4'h1, 32'h0,        0, 1, 32'hFFFFCDAB, 0, 3};
      vecs[5]  = '{1, 1, 0, 0, 32'h40,         32'h5,         0, 32'h0,        32'h0,        0, 32'h0,         4'h0, 32'h0,        32'h0,       4'h0, 32'h0,        0, 1, 32'hFFFFCDAB, 1, 1};
      vecs[6]  = '{1, 0, 3, 0, 32'h40,         32'h0,         0, 32'h0,        32'h0,        0, 32'h0,         4'h0, 32'h0,        32'h0,       4'h0, 32'h0,        0, 1, 32'hFFFFCDAB, 1, 1};
      vecs[7]  = '{1, 0, 1, 1, 32'h22,         32'h0,         2, 32'h80017777, 32'h0,        1, 32'h20,        4'hC, 32'h0,        32'h0,       4'h0, 32'h0,        0, 1, 32'h00008001, 0, 4};
      vecs[8]  = '{0, 1, 2, 1, 32'h301,        32'h123456A5,  0, 32'h0,        32'h0,        1, 32'h300,       4'h2, 32'h3456A500, 32'h0,       4'h0, 32'h0,        1, 0, 32'h0,        0, 2};
      vecs[9]  = '{1, 0, 0, 0, 32'hFFFFFFFD,   32'h0,         0, 32'h44332211, 32'h000000AA, 2, 32'hFFFFFFFC,  4'hE, 32'h0,        32'h0,       4'h1, 32'h0,        0, 1, 32'hAA443322, 0, 3};
      vecs[10] = '{1, 0, 1, 0, 32'h10,         32'h0,         0, 32'h1234F00D, 32'h0,        1, 32'h10,        4'h3, 32'h0,        32'h0,       4'h0, 32'h0,        0, 1, 32'hFFFFF00D, 0, 2};
      vecs[11] = '{0, 1, 0, 0, 32'h3,          32'hAABBCCDD,  1, 32'h0,        32'h0,        2, 32'h0,         4'h8, 32'hDD000000, 32'h4,       4'h7, 32'h00AABBCC, 1, 0, 32'h0,        0, 5};

      reset = 1; mem_read = 0; mem_write = 0; inst_size = 0; ld_unsigned = 0;
      addr = 0; wdata = 0; dmem_ack = 0; dmem_rdata = 0;
      repeat (3) @(negedge clk);
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_done",  {31'h0, done}, 32'h0);
      check("rst_err",   {31'h0, err}, 32'h0);
      check("rst_req",   {31'h0, dmem_req}, 32'h0);
      check("rst_we",    {31'h0, dmem_we}, 32'h0);
      check("rst_be",    {28'h0, dmem_be}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_addr",  dmem_addr, 32'h0);
      check("rst_wdata", dmem_wdata, 32'h0);
      reset = 0;

      for (int i = 0; i < 12; i++) begin
         run_access(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd,
                    vecs[i].dly, vecs[i].w0, vecs[i].w1);
         check($sformatf("v%0d_done", i), {31'h0, got_done}, 32'h1);
         check($sformatf("v%0d_ntx", i), n_tx, vecs[i].ntx);
         check($sformatf("v%0d_err", i), {31'h0, got_err}, {31'h0, vecs[i].err});
         check($sformatf("v%0d_stall_cycles", i), stall_cnt, vecs[i].stl);
         check($sformatf("v%0d_stall_in_done", i), {31'h0, stall_in_done}, 32'h0);
         check($sformatf("v%0d_hold", i), {31'h0, hold_ok}, 32'h1);
         if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), got_rdata, vecs[i].rd_exp);
         if (n_tx >= 1 && vecs[i].ntx >= 1) begin
            check($sformatf("v%0d_addr0", i), cap_addr[0], vecs[i].a0);
            check($sformatf("v%0d_be0", i), {28'h0, cap_be[0]}, {28'h0, vecs[i].be0});
            check($sformatf("v%0d_we0", i), {31'h0, cap_we[0]}, {31'h0, vecs[i].we});
            if (vecs[i].wr) check($sformatf("v%0d_wdata0", i), cap_wdata[0], vecs[i].wd0);
         end
         if (n_tx == 2 && vecs[i].ntx == 2) begin
            check($sformatf("v%0d_addr1", i), cap_addr[1], vecs[i].a1);
            check($sformatf("v%0d_be1", i), {28'h0, cap_be[1]}, {28'h0, vecs[i].be1});
            check($sformatf("v%0d_we1", i), {31'h0, cap_we[1]}, {31'h0, vecs[i].we});
            if (vecs[i].wr) check($sformatf("v%0d_wdata1", i), cap_wdata[1], vecs[i].wd1);
         end
      end

      // Reset while the second beat of a split load is outstanding.
      @(negedge clk);
      mem_read = 1; inst_size = 2'b00; ld_unsigned = 0; addr = 32'h1FE;
      @(negedge clk);
      mem_read = 0; dmem_ack = 1; dmem_rdata = 32'h12345678;
      @(negedge clk);
      dmem_ack = 0;
      #1;
      check("mid_acc1_req", {31'h0, dmem_req}, 32'h1);
      check("mid_acc1_addr", dmem_addr, 32'h200);
      reset = 1;
      @(negedge clk);
      #1;
      check("mid_rst_req", {31'h0, dmem_req}, 32'h0);
      check("mid_rst_stall", {31'h0, stall}, 32'h0);
      check("mid_rst_done", {31'h0, done}, 32'h0);
      check("mid_rst_be", {28'h0, dmem_be}, 32'h0);
      check("mid_rst_rdata", rdata, 32'h0);
      reset = 0;
      dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      #1;
      check("post_rst_done", {31'h0, done}, 32'h0);
      check("post_rst_req", {31'h0, dmem_req}, 32'h0);
      dmem_ack = 0;

      // A fresh access after reset release still works.
      run_access(1, 0, 2'b00, 0, 32'h100, 32'h0, 0, 32'hCAFEF00D, 32'h0);
      check("post_rst_access_done", {31'h0, got_done}, 32'h1);
      check("post_rst_access_rdata", got_rdata, 32'hCAFEF00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_control.md
LSU_CONTROL -- requirements
Module: lsu_control

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning data-memory address width in bits.
REQ-002 SHALL have port clk, input, 1, single system clock (rising edge).
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port mem_read, input, 1, decoded load request.
REQ-005 SHALL have port mem_write, input, 1, decoded store request.
REQ-006 SHALL have port inst_size, input, 2, access size: 00 word, 01 half, 10 byte, 11 illegal.
REQ-007 SHALL have port ld_unsigned, input, 1, zero-extend on load (funct3[2]).
REQ-008 SHALL have port addr, input, ADDR_W, byte address from the ALU.
REQ-009 SHALL have port wdata, input, 32, store data from rs2.
REQ-010 SHALL have port stall, output, 1, hold the pipeline.
REQ-011 SHALL have port rdata, output, 32, extended load result.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1, illegal access, valid with done.
REQ-014 SHALL have memory ports dmem_req (out, 1), dmem_we (out, 1), dmem_addr (out, ADDR_W, word-aligned), dmem_be (out, 4), dmem_wdata (out, 32), dmem_ack (in, 1), dmem_rdata (in, 32).

Function
REQ-015 SHALL implement FSM states IDLE, ACC0, ACC1, DONE.
REQ-016 IDLE: inputs are sampled only here; mem_read or mem_write high -> latch addr, wdata, size, ld_unsigned and direction, then go to ACC0.
REQ-017 stall SHALL equal (state is ACC0 or ACC1) or (state is IDLE and mem_read or mem_write); stall SHALL be 0 in DONE.
REQ-018 Access is misaligned-split when offset plus bytes exceeds 4 (half at offset 3; word at offsets 1-3).
REQ-019 ACC0: dmem_req=1, dmem_addr=addr with bits [1:0] cleared, be=lane mask shifted left by offset and truncated to 4 bits, wdata shifted left by 8*offset.
REQ-020 ACC0 with dmem_ack: go to ACC1 if split, else go to DONE. Read data SHALL be captured on the ack cycle.
REQ-021 ACC1: dmem_addr=first word address+4 (wraps modulo 2^ADDR_W), be=overflow lanes, wdata=store data shifted right by 8*(4-offset); on ack go to DONE.
REQ-022 dmem_req, addr, be, we and wdata SHALL be held stable until ack.
REQ-023 DONE lasts exactly 1 cycle: done=1; rdata valid; the next state is IDLE unconditionally.
REQ-024 Load result SHALL be {hi_word,lo_word} shifted right by 8*offset, masked to the size, then sign-extended, or zero-extended when ld_unsigned is set. It SHALL hold until the next DONE.
REQ-025 mem_read and mem_write both high, or inst_size=11: no memory access; go IDLE->DONE with err=1 and rdata unchanged.
REQ-026 dmem_we SHALL be 1 for stores only; the store-side ld_unsigned SHALL be ignored.
REQ-027 While waiting for ack, latency is unbounded; no timeout.

Reset
REQ-028 reset SHALL force state IDLE, and stall, done, err, dmem_req, dmem_we and dmem_be to 0, with rdata, dmem_addr and dmem_wdata at 0, on the next edge. This SHALL apply mid-access, and SHALL discard the pending access.
REQ-029 After reset release, the first access SHALL begin no earlier than the first cycle with reset low.

Structure
REQ-030 Shared package SHALL hold the size encodings WORD/HALF/BYTE and the FSM state typedef.
REQ-031 Byte-lane shifting, masking and extension SHALL sit in a combinational sub-module lsu_align; the FSM stays in lsu_control.

Verification
REQ-032 Aligned word load, addr=0x100, ack after 2 cycles, dmem_rdata=0xDEADBEEF -> one request at 0x100, be=1111, done with rdata=0xDEADBEEF, stall high 3 cycles.
REQ-033 Byte load addr=0x103, rdata word 0x80xxxxxx -> be=1000, rdata=0xFFFFFF80 signed, and 0x00000080 with ld_unsigned.
REQ-034 Misaligned word store addr=0x1FE, wdata=0x11223344 -> ACC0 at 0x1FC, be=1100, wdata=0x33440000; ACC1 at 0x200, be=0011, wdata=0x00001122.
REQ-035 Misaligned half load addr=0x7, words 0xAB000000 then 0x000000CD -> rdata=0xFFFFCDAB.
REQ-036 Reset asserted in ACC1 before ack -> dmem_req=0 and state IDLE on the next edge, with no done pulse.
REQ-037 mem_read=mem_write=1 -> no dmem_req, and done=err=1 one cycle later.
